// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x 64-bit entry storage, one synchronous write port and one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner guarantees writes only go to free slots.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode prefetch FIFO of {PC+4, instr}; empty head reads as zero (NOP bubble); flush discards all.
// Latency: 1 cycle push-to-head; 0 cycles through the bypass when FETCH_QUEUE_BYPASS_EN is defined.
// Backpressure: in_ready = (count != DEPTH), purely registered; freeze holds the head entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  input  logic          flush,
  input  logic          freeze,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  assign empty    = (count == '0);
  assign in_ready = (count != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // An instruction arriving at an empty, unstalled queue goes straight to decode and is never stored.
  assign bypass = empty & in_valid & ~freeze & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Stored entries only; a bypassed instruction is neither pushed nor popped.
  assign push = in_valid & in_ready & ~flush & ~bypass;
  assign pop  = ~empty & ~freeze & ~flush;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Head selection: stored entry, else the bypassed input, else a zero NOP bubble.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'h0;
    out_instr = NOP_INSTR;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = head_entry.pc;
      out_instr = head_entry.instr;
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  // Pointer and occupancy update; flush empties the queue and suppresses push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        freeze;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave time for outputs to settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_in_q[$];
  int          popped;

  initial begin
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    tick();
    check("idle_count", 32'(count), 32'd0);
    check("idle_out_instr", out_instr, 32'h0);

    // Fill with decode frozen
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'hE3A0_1001 + 32'(i));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_head_pc", out_pc, 32'd4);

    // Drain in order, one per cycle
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_pc", out_pc, 32'(4 * (i + 1)));
      check("drain_instr", out_instr, 32'hE3A0_1001 + 32'(i));
      tick();
      if (i == 0) check("drain_in_ready", 32'(in_ready), 32'd1);
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_nop", out_instr, 32'h0);

    // Full plus concurrent pop
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    freeze = 1'b0;
    drive(1'b1, 32'h50, 32'hB0);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_pc, 32'h40);
    tick();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_in_ready", 32'(in_ready), 32'd1);
    check("fullpop_head", out_pc, 32'h44);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("late_push_count", 32'(count), 32'd3);
    check("late_push_head", out_pc, 32'h48);
    tick();
    check("tail_pc1", out_pc, 32'h4C);
    tick();
    check("tail_pc2", out_pc, 32'h50);
    check("tail_instr2", out_instr, 32'hB0);
    tick();
    check("tail_empty", 32'(count), 32'd0);

    // Flush mid-stream with an in-flight fetch
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h60 + 32'(4 * i), 32'hC0 + 32'(i));
      tick();
    end
    check("preflush_count", 32'(count), 32'd3);
    drive(1'b1, 32'h99, 32'h99);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_pc", out_pc, 32'h0);
    drive(1'b1, 32'h100, 32'hD0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("post_flush_count", 32'(count), 32'd1);
    check("post_flush_head", out_pc, 32'h100);
    freeze = 1'b0;
    tick();
    check("post_flush_drain", 32'(count), 32'd0);

    // Wrap-around: 10 push/pop pairs with freeze low
    popped = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) begin
        drive(1'b1, 32'h200 + 32'(4 * c), 32'hF000 + 32'(c));
        exp_pc_q.push_back(32'h200 + 32'(4 * c));
        exp_in_q.push_back(32'hF000 + 32'(c));
      end else begin
        drive(1'b0, 32'h0, 32'h0);
      end
      #1;
      if (out_valid && exp_pc_q.size() > 0) begin
        check("wrap_pc", out_pc, exp_pc_q.pop_front());
        check("wrap_instr", out_instr, exp_in_q.pop_front());
        popped++;
      end
      check("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
      tick();
    end
    check("wrap_popped", 32'(popped), 32'd10);
    check("wrap_end_count", 32'(count), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass: empty queue, unstalled
    drive(1'b1, 32'h20, 32'h1234);
    #1;
    check("byp_out_valid", 32'(out_valid), 32'd1);
    check("byp_out_pc", out_pc, 32'h20);
    tick();
    check("byp_count", 32'(count), 32'd0);
    freeze = 1'b1;
    #1;
    check("byp_frozen_valid", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("byp_frozen_count", 32'(count), 32'd1);
    check("byp_frozen_head", out_pc, 32'h20);
    freeze = 1'b0;
    tick();
`endif

    // Reset asserted mid-operation clears immediately
    freeze = 1'b1;
    drive(1'b1, 32'h300, 32'h300);
    tick();
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
